pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 89 ++++++++
 tb/tb_pipe_adder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// Chunked carry-pipelined adder/subtractor: one CHUNK-bit slice per stage, operands
// skewed forward, finished sum chunks deskewed so the result leaves as a full word.
module pipe_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int STAGES = WIDTH / CHUNK;

  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];

  logic [CHUNK:0]   part [STAGES];
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             adv;

  // Subtraction is folded into operand B at entry so the mode needs no further tracking.
  assign b_eff   = sub ? ~in2 : in2;
  assign cin_eff = sub | cin;

  assign adv      = ~(v_q[STAGES-1] & ~out_ready);
  assign in_ready = adv;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      part[k] = '0;
    end
    part[0] = {1'b0, in1[CHUNK-1:0]} + {1'b0, b_eff[CHUNK-1:0]} + (CHUNK+1)'(cin_eff);
    for (int k = 1; k < STAGES; k++) begin
      part[k] = {1'b0, a_q[k-1][k*CHUNK +: CHUNK]}
              + {1'b0, b_q[k-1][k*CHUNK +: CHUNK]}
              + (CHUNK+1)'(c_q[k-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      v_q[0] <= in_valid;
      if (in_valid) begin
        a_q[0]              <= in1;
        b_q[0]              <= b_eff;
        c_q[0]              <= part[0][CHUNK];
        s_q[0]              <= '0;
        s_q[0][CHUNK-1:0]   <= part[0][CHUNK-1:0];
      end
      for (int k = 1; k < STAGES; k++) begin
        v_q[k]                    <= v_q[k-1];
        a_q[k]                    <= a_q[k-1];
        b_q[k]                    <= b_q[k-1];
        c_q[k]                    <= part[k][CHUNK];
        s_q[k]                    <= s_q[k-1];
        s_q[k][k*CHUNK +: CHUNK]  <= part[k][CHUNK-1:0];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                     (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder (WIDTH=16, CHUNK=4): hand-computed results checked
// in order by a negedge monitor, plus explicit latency, stall, bubble and reset checks.
module tb_pipe_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in1 = '0;
  logic [15:0] in2 = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int n_chk = 0;
  int n_err = 0;
  logic [17:0] exp_q [$];

  pipe_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .cin(cin), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .cout(cout), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic s, input logic v);
    in1 = a; in2 = b; cin = c; sub = s; in_valid = v;
  endtask

  // Expected entries are {cout, ovf, sum}; each output transfer consumes one in order.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chk("result_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("result", {14'd0, cout, ovf, sum}, {14'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bp_a [6];
    logic [15:0] bp_b [6];
    logic        bp_s [6];
    logic [17:0] bp_e [6];

    bp_a = '{16'h1234, 16'h7000, 16'h0FFF, 16'h3A5C, 16'h7FFF, 16'h0100};
    bp_b = '{16'h0101, 16'h1000, 16'h0001, 16'h25A3, 16'h7FFF, 16'h00FF};
    bp_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bp_e = '{{2'b00, 16'h1335}, {2'b01, 16'h8000}, {2'b00, 16'h1000},
             {2'b00, 16'h5FFF}, {2'b01, 16'hFFFE}, {2'b10, 16'h0001}};

    // reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'h0000);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;

    // full ripple through every chunk, then the same with carry-in
    drive(16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b1);
    exp_q.push_back({2'b00, 16'hFFFF});
    tick();
    drive(16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b1);
    exp_q.push_back({2'b10, 16'h0000});
    tick();
    drive(16'hDEAD, 16'hBEEF, 1'b1, 1'b1, 1'b0);
    tick();
    @(negedge clk);
    chk("ripple_not_early", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("ripple_valid", 32'(out_valid), 32'd1);
    chk("ripple_sum", 32'(sum), 32'hFFFF);
    chk("ripple_cout", 32'(cout), 32'd0);
    tick();
    @(negedge clk);
    chk("ripple_cin_valid", 32'(out_valid), 32'd1);
    chk("ripple_cin_sum", 32'(sum), 32'h0000);
    chk("ripple_cin_cout", 32'(cout), 32'd1);
    tick();

    // subtract / overflow, mixed modes back to back (cin must be ignored in sub)
    drive(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
    exp_q.push_back({2'b00, 16'hFFFE});
    tick();
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    exp_q.push_back({2'b01, 16'h8000});
    tick();
    drive(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    exp_q.push_back({2'b11, 16'h7FFF});
    tick();
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (6) tick();
    chk("ovf_drained", 32'(exp_q.size()), 32'd0);

    // backpressure: 6 sets, consumer stalls 3 cycles at the first result
    fork
      begin
        int i = 0;
        int guard = 0;
        logic acc;
        while (i < 6 && guard < 40) begin
          drive(bp_a[i], bp_b[i], 1'b0, bp_s[i], 1'b1);
          @(negedge clk);
          acc = in_ready;
          tick();
          guard++;
          if (acc) begin
            exp_q.push_back(bp_e[i]);
            i++;
          end
        end
        in_valid = 1'b0;
        chk("bp_all_sent", 32'(i), 32'd6);
      end
      begin
        int w = 0;
        while (!out_valid && w < 20) begin
          tick();
          w++;
        end
        chk("bp_first_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready_low", 32'(in_ready), 32'd0);
          chk("bp_sum_hold", 32'(sum), 32'h1335);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    begin
      int w = 0;
      while (exp_q.size() != 0 && w < 30) begin
        tick();
        w++;
      end
    end
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    tick();

    // bubbles: in_valid 1,0,1,0 with garbage on the idle cycles
    drive(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
    exp_q.push_back({2'b00, 16'h0003});
    tick();
    drive(16'hDEAD, 16'hBEEF, 1'b1, 1'b1, 1'b0);
    tick();
    drive(16'h00F0, 16'h0F0F, 1'b0, 1'b0, 1'b1);
    exp_q.push_back({2'b00, 16'h0FFF});
    tick();
    drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    chk("bub_v0", 32'(out_valid), 32'd1);
    tick();
    @(negedge clk);
    chk("bub_v1", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("bub_v2", 32'(out_valid), 32'd1);
    tick();
    @(negedge clk);
    chk("bub_v3", 32'(out_valid), 32'd0);
    tick();
    chk("bub_drained", 32'(exp_q.size()), 32'd0);

    // reset mid-flight: nothing accepted before it may come out afterwards
    drive(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    tick();
    drive(16'h3333, 16'h4444, 1'b0, 1'b0, 1'b1);
    tick();
    drive(16'h5555, 16'h6666, 1'b0, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      @(negedge clk);
      chk("midrst_flushed", 32'(out_valid), 32'd0);
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
